multicycle_control: RTL
=======================

# multicycle_control

Multicycle RISC-V main control FSM. It sequences fetch, decode, execute, memory and writeback for a 32-bit instruction. It drives the datapath strobes and muxes, and it produces the `alu_cmd` that the ALU control decoder consumes. It also handles the ready handshake with the shared instruction/data memory.

## Interface
- No parameters.
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high.
- `instruction` in 32: instruction-register contents, valid from DECODE onward.
- `mem_ready` in 1: memory completes the current read/write on this edge.
- `rs_equal` in 1: datapath comparator, rs1 == rs2.
- `state` out 4: current state encoding.
- `mem_read`, `mem_write` out 1: memory request, held until `mem_ready`.
- `iord` out 1: memory address select, 0 = PC, 1 = ALUOut.
- `ir_load` out 1: load IR and old_pc.
- `pc_load` out 1: PC write.
- `pc_src` out 1: PC source, 0 = ALU result, 1 = target register.
- `target_load` out 1: load branch/jump target register from ALU.
- `rf_write` out 1: register-file write.
- `wb_sel` out 2: writeback source, 00 = ALUOut, 01 = MDR, 10 = PC.
- `alu_src_a` out 2: ALU A operand, 00 = PC, 01 = old_pc, 10 = rs1.
- `alu_src_b` out 2: ALU B operand, 00 = rs2, 01 = const 4, 10 = imm.
- `imm_sel` out 2: immediate format, 0 = I, 1 = S, 2 = B, 3 = J.
- `alu_cmd` out 4: 0000 = decode from funct3/funct7, 0001 = add, 0010 = add, 0011 = and.
- `illegal` out 1: sticky trap flag.

## Operation
- Opcodes are taken from `instruction[6:0]`, funct3 from `[14:12]`.
- States and encodings:
  - FETCH = 0
  - DECODE = 1
  - EXEC_R = 2
  - EXEC_I = 3
  - ALU_WB = 4
  - MEM_ADDR = 5
  - MEM_RD = 6
  - MEM_WB = 7
  - MEM_WR = 8
  - BRANCH = 9
  - JAL = 10
  - TRAP = 15
- Any other encoding returns to FETCH.
- FETCH: `mem_read`=1, `iord`=0, A=PC, B=4, `alu_cmd`=0001.
  - While `mem_ready`=0, stay.
  - When `mem_ready`=1, same cycle: `ir_load`=1, `pc_load`=1, `pc_src`=0; next state DECODE.
- DECODE: A=old_pc, B=imm, `alu_cmd`=0010, `target_load`=1. `imm_sel` follows opcode (I/S/B/J). Next state:
  - 0110011 -> EXEC_R.
  - 0010011 with funct3 000/111 -> EXEC_I.
  - 0000011 with funct3 010, or 0100011 with funct3 010 -> MEM_ADDR.
  - 1100011 with funct3 000 -> BRANCH.
  - 1101111 -> JAL (see Configuration).
  - Anything else -> TRAP.
- EXEC_R: A=rs1, B=rs2, `alu_cmd`=0000 -> ALU_WB.
- EXEC_I: A=rs1, B=imm, `imm_sel`=I; `alu_cmd` = 0001 (addi) or 0011 (andi) -> ALU_WB.
- ALU_WB: `rf_write`=1, `wb_sel`=00 -> FETCH.
- MEM_ADDR: A=rs1, B=imm, `imm_sel` I (load) or S (store), `alu_cmd`=0001 -> MEM_RD for load, MEM_WR for store.
- MEM_RD: `mem_read`=1, `iord`=1; stay until `mem_ready` -> MEM_WB.
- MEM_WB: `rf_write`=1, `wb_sel`=01 -> FETCH.
- MEM_WR: `mem_write`=1, `iord`=1; stay until `mem_ready` -> FETCH.
- BRANCH: `pc_load`=`rs_equal`, `pc_src`=1 -> FETCH.
- JAL: `rf_write`=1, `wb_sel`=10 (PC already +4), `pc_load`=1, `pc_src`=1 -> FETCH.
- TRAP: all strobes 0, `illegal`=1; exit only by reset.
- Every output not listed for a state is 0.

## Timing
- `state` is registered. Outputs are combinational from `state`; `ir_load`/`pc_load` also depend on `mem_ready` (FETCH) and `rs_equal` (BRANCH).
- Reset while `reset`=1: all outputs forced 0; next state FETCH; `illegal` cleared. Reset overrides any state, including a pending memory wait. An aborted request is simply dropped.
- `mem_read`/`mem_write` stay high and stable through every wait cycle. They deassert in the cycle after `mem_ready` is sampled high. `mem_ready` is ignored in all non-memory states.
- Latency with zero-wait memory:
  - R/I-type: 4 cycles.
  - load: 5.
  - store: 4.
  - beq: 3.
  - jal: 3.
- Each memory wait cycle adds 1.
- Never are both `mem_read` and `mem_write` high.

## Configuration
- `JAL_EN` defined: opcode 1101111 decodes to JAL as above.
- `JAL_EN` undefined: 1101111 goes to TRAP; state 10 is unreachable and treated as an invalid encoding (returns to FETCH).

## Test plan
- add 0x002081B3, `mem_ready`=1 -> states 0,1,2,4,0; `alu_cmd`=0000 in EXEC_R; `rf_write`=1, `wb_sel`=00 in ALU_WB only.
- lw 0x0080A283, `mem_ready` low 3 cycles in MEM_RD -> `mem_read`=1, `iord`=1 for 4 cycles; then MEM_WB with `rf_write`=1, `wb_sel`=01; 8 cycles total.
- beq 0x00208463 with `rs_equal`=1 -> `pc_load`=1, `pc_src`=1 in BRANCH. With `rs_equal`=0 -> `pc_load`=0. Next state FETCH in both.
- 0xFFFFFFFF -> TRAP after DECODE; `illegal`=1 and all strobes 0 for 20 cycles; `reset` -> state 0, `illegal`=0.
- jal 0x010000EF, `JAL_EN` on -> state 10, `rf_write`=1, `wb_sel`=10, `pc_load`=1. `JAL_EN` off -> TRAP.
- sw with `mem_ready`=0, `reset` pulsed in MEM_WR -> `mem_write`=0 during reset; state 0 afterwards; fetch restarts with `mem_read`=1.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle RISC-V main control FSM: fetch/decode/execute/memory/writeback sequencing.
// Optional feature: define JAL_EN to decode opcode 1101111 (jal); otherwise jal traps.
module multicycle_control (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic        mem_ready,
  input  logic        rs_equal,
  output logic [3:0]  state,
  output logic        mem_read,
  output logic        mem_write,
  output logic        iord,
  output logic        ir_load,
  output logic        pc_load,
  output logic        pc_src,
  output logic        target_load,
  output logic        rf_write,
  output logic [1:0]  wb_sel,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  imm_sel,
  output logic [3:0]  alu_cmd,
  output logic        illegal
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_ALU_WB   = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_MEM_WB   = 4'd7,
    S_MEM_WR   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd15
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_BEQ = 3'b000;

  localparam logic [1:0] IMM_I = 2'd0;
  localparam logic [1:0] IMM_S = 2'd1;
  localparam logic [1:0] IMM_B = 2'd2;
  localparam logic [1:0] IMM_J = 2'd3;

  localparam logic [1:0] A_PC     = 2'b00;
  localparam logic [1:0] A_OLD_PC = 2'b01;
  localparam logic [1:0] A_RS1    = 2'b10;
  localparam logic [1:0] B_RS2    = 2'b00;
  localparam logic [1:0] B_FOUR   = 2'b01;
  localparam logic [1:0] B_IMM    = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MDR = 2'b01;
  localparam logic [1:0] WB_PC  = 2'b10;

  localparam logic [3:0] CMD_FUNCT = 4'b0000;
  localparam logic [3:0] CMD_ADD   = 4'b0001;
  localparam logic [3:0] CMD_ADD_T = 4'b0010;
  localparam logic [3:0] CMD_AND   = 4'b0011;

  state_t     state_q;
  state_t     next_state;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_store;
  logic       unused_bits;

  assign opcode      = instruction[6:0];
  assign funct3      = instruction[14:12];
  assign is_store    = (opcode == OP_STORE);
  assign unused_bits = ^{instruction[31:15], instruction[11:7]};

  function automatic logic [1:0] imm_for(input logic [6:0] op);
    case (op)
      OP_STORE:  imm_for = IMM_S;
      OP_BRANCH: imm_for = IMM_B;
      OP_JAL:    imm_for = IMM_J;
      default:   imm_for = IMM_I;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= next_state;
  end

  always_comb begin
    next_state = S_FETCH;
    case (state_q)
      S_FETCH:  next_state = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        next_state = S_TRAP;
        case (opcode)
          OP_R:      next_state = S_EXEC_R;
          OP_IMM:    if (funct3 == F3_ADD || funct3 == F3_AND) next_state = S_EXEC_I;
          OP_LOAD:   if (funct3 == F3_W) next_state = S_MEM_ADDR;
          OP_STORE:  if (funct3 == F3_W) next_state = S_MEM_ADDR;
          OP_BRANCH: if (funct3 == F3_BEQ) next_state = S_BRANCH;
`ifdef JAL_EN
          OP_JAL:    next_state = S_JAL;
`endif
          default:   next_state = S_TRAP;
        endcase
      end
      S_EXEC_R:   next_state = S_ALU_WB;
      S_EXEC_I:   next_state = S_ALU_WB;
      S_ALU_WB:   next_state = S_FETCH;
      S_MEM_ADDR: next_state = is_store ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   next_state = mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WB:   next_state = S_FETCH;
      S_MEM_WR:   next_state = mem_ready ? S_FETCH : S_MEM_WR;
      S_BRANCH:   next_state = S_FETCH;
`ifdef JAL_EN
      S_JAL:      next_state = S_FETCH;
`endif
      S_TRAP:     next_state = S_TRAP;
      default:    next_state = S_FETCH;
    endcase
  end

  // Reset blanks every output combinationally so an in-flight memory request drops immediately.
  assign state = reset ? 4'd0 : state_q;

  always_comb begin
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    iord        = 1'b0;
    ir_load     = 1'b0;
    pc_load     = 1'b0;
    pc_src      = 1'b0;
    target_load = 1'b0;
    rf_write    = 1'b0;
    wb_sel      = WB_ALU;
    alu_src_a   = A_PC;
    alu_src_b   = B_RS2;
    imm_sel     = IMM_I;
    alu_cmd     = CMD_FUNCT;
    illegal     = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_a = A_PC;
          alu_src_b = B_FOUR;
          alu_cmd   = CMD_ADD;
          ir_load   = mem_ready;
          pc_load   = mem_ready;
        end
        S_DECODE: begin
          alu_src_a   = A_OLD_PC;
          alu_src_b   = B_IMM;
          alu_cmd     = CMD_ADD_T;
          target_load = 1'b1;
          imm_sel     = imm_for(opcode);
        end
        S_EXEC_R: begin
          alu_src_a = A_RS1;
          alu_src_b = B_RS2;
          alu_cmd   = CMD_FUNCT;
        end
        S_EXEC_I: begin
          alu_src_a = A_RS1;
          alu_src_b = B_IMM;
          imm_sel   = IMM_I;
          alu_cmd   = (funct3 == F3_AND) ? CMD_AND : CMD_ADD;
        end
        S_ALU_WB: begin
          rf_write = 1'b1;
          wb_sel   = WB_ALU;
        end
        S_MEM_ADDR: begin
          alu_src_a = A_RS1;
          alu_src_b = B_IMM;
          imm_sel   = is_store ? IMM_S : IMM_I;
          alu_cmd   = CMD_ADD;
        end
        S_MEM_RD: begin
          mem_read = 1'b1;
          iord     = 1'b1;
        end
        S_MEM_WB: begin
          rf_write = 1'b1;
          wb_sel   = WB_MDR;
        end
        S_MEM_WR: begin
          mem_write = 1'b1;
          iord      = 1'b1;
        end
        S_BRANCH: begin
          pc_load = rs_equal;
          pc_src  = 1'b1;
        end
`ifdef JAL_EN
        // PC was already advanced by 4 in FETCH, so it is the link value here.
        S_JAL: begin
          rf_write = 1'b1;
          wb_sel   = WB_PC;
          pc_load  = 1'b1;
          pc_src   = 1'b1;
        end
`endif
        S_TRAP:  illegal = 1'b1;
        default: illegal = 1'b0;
      endcase
    end
  end

endmodule
